stopwatch_ctrl: RTL and testbench

- Top-level run/pause/lap/clear sequencer for the VGA stopwatch.
- Samples the two raw active-low pushbuttons (start/stop, lap/reset) at a slow debounce tick and converts each press into a single event.
- Drives the time-counter enable and clear, the lap-register latch and the display freeze.
- Sits between the board buttons and the time counter / VGA digit renderer.

---
 rtl/stopwatch_ctrl_pkg.sv | 31 +++
 rtl/stopwatch_ctrl_if.sv | 25 ++
 rtl/btn_press_det.sv | 31 +++
 rtl/stopwatch_ctrl.sv | 146 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared constants for the stopwatch controller: state encodings, clock and
// debounce defaults, and the output bundle type.
package stopwatch_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_LAP   = 2'b11;

    localparam int CLK_FREQ_HZ    = 50_000_000;
    localparam int SAMPLE_DIV_DEF = 500_000;

    typedef struct packed {
        logic       count_en;
        logic       count_clr;
        logic       lap_latch;
        logic       disp_freeze;
        logic [1:0] state;
    } ctl_out_t;

    // Level outputs are a pure function of the state being entered.
    function automatic ctl_out_t ctl_levels(input logic [1:0] st);
        ctl_out_t o;
        o             = '0;
        o.state       = st;
        o.count_en    = (st == ST_RUN) || (st == ST_LAP);
        o.disp_freeze = (st == ST_LAP);
        return o;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Control bundle from the stopwatch sequencer to the time counter,
// lap register and VGA digit renderer.
interface stopwatch_ctrl_if;
    logic       count_en;
    logic       count_clr;
    logic       lap_latch;
    logic       disp_freeze;
    logic [1:0] state_o;

    modport master (
        output count_en,
        output count_clr,
        output lap_latch,
        output disp_freeze,
        output state_o
    );

    modport slave (
        input count_en,
        input count_clr,
        input lap_latch,
        input disp_freeze,
        input state_o
    );
endinterface

// File: rtl/btn_press_det.sv
// Raw active-low button -> 2-flop synchroniser -> tick-rate sample ->
// single-clk press event on a released-to-pressed sample transition.
module btn_press_det (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_n,
    output logic press,
    output logic level
);

    logic [1:0] sync_q;
    logic       samp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            samp_q <= 1'b1;
            press  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_n};
            press  <= tick && !sync_q[1] && samp_q;
            if (tick) begin
                samp_q <= sync_q[1];
            end
        end
    end

    assign level = sync_q[1];

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear sequencer for the VGA stopwatch.
// Optional long-hold clear on the lap button: STOPWATCH_CTRL_HOLD_CLR_EN.
//
//   state | meaning
//   IDLE  | stopped at zero, waiting for start
//   RUN   | counter advancing, live time shown
//   PAUSE | counter held, live time shown
//   LAP   | counter advancing, display frozen on lap register
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int DIV_W      = 19,
    parameter int HOLD_TICKS = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_ss_n,
    input  logic btn_lap_n,
    stopwatch_ctrl_if.master ctl
);

    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic             ss_evt;
    logic             lap_evt;
    logic             ss_level;
    logic             lap_level;
    logic             hold_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));

    btn_press_det u_ss_det (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .btn_n (btn_ss_n),
        .press (ss_evt),
        .level (ss_level)
    );

    btn_press_det u_lap_det (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .btn_n (btn_lap_n),
        .press (lap_evt),
        .level (lap_level)
    );

`ifdef STOPWATCH_CTRL_HOLD_CLR_EN
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    logic [HOLD_W-1:0] hold_q;

    // Event fires on the tick that reaches HOLD_TICKS; saturation blocks repeats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q   <= '0;
            hold_evt <= 1'b0;
        end else begin
            hold_evt <= 1'b0;
            if (tick) begin
                if (lap_level) begin
                    hold_q <= '0;
                end else if (hold_q != HOLD_W'(HOLD_TICKS)) begin
                    hold_q   <= hold_q + 1'b1;
                    hold_evt <= (hold_q == HOLD_W'(HOLD_TICKS - 1));
                end
            end
        end
    end

    logic unused_levels;
    assign unused_levels = ss_level;
`else
    assign hold_evt = 1'b0;

    logic unused_levels;
    assign unused_levels = ^{ss_level, lap_level, 32'(HOLD_TICKS)};
`endif

    logic [1:0] state_q;
    logic [1:0] state_nxt;
    logic       clr_nxt;
    logic       lat_nxt;
    ctl_out_t   out_q;

    always_comb begin
        state_nxt = state_q;
        clr_nxt   = 1'b0;
        lat_nxt   = 1'b0;
        if (hold_evt) begin
            state_nxt = ST_IDLE;
            clr_nxt   = 1'b1;
        end else if (ss_evt) begin
            case (state_q)
                ST_IDLE:  state_nxt = ST_RUN;
                ST_RUN:   state_nxt = ST_PAUSE;
                ST_PAUSE: state_nxt = ST_RUN;
                default:  state_nxt = ST_PAUSE;
            endcase
        end else if (lap_evt) begin
            case (state_q)
                ST_RUN, ST_LAP: begin
                    state_nxt = ST_LAP;
                    lat_nxt   = 1'b1;
                end
                ST_PAUSE: begin
                    state_nxt = ST_IDLE;
                    clr_nxt   = 1'b1;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
        end else begin
            state_q         <= state_nxt;
            out_q           <= ctl_levels(state_nxt);
            out_q.count_clr <= clr_nxt;
            out_q.lap_latch <= lat_nxt;
        end
    end

    assign ctl.count_en    = out_q.count_en;
    assign ctl.count_clr   = out_q.count_clr;
    assign ctl.lap_latch   = out_q.lap_latch;
    assign ctl.disp_freeze = out_q.disp_freeze;
    assign ctl.state_o     = out_q.state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a table-driven stopwatch model queues
// the expected output updates, a negedge monitor pops and compares them.
module tb_stopwatch_ctrl;
    import stopwatch_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_ss_n = 1'b1;
    logic btn_lap_n = 1'b1;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(
        .SAMPLE_DIV (4),
        .DIV_W      (3),
        .HOLD_TICKS (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_ss_n  (btn_ss_n),
        .btn_lap_n (btn_lap_n),
        .ctl       (sw_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // record = {state, count_en, disp_freeze, count_clr, lap_latch}
    logic [5:0] exp_q[$];
    logic [1:0] mode = ST_IDLE;

    logic [1:0] ss_to[4]   = '{ST_RUN, ST_PAUSE, ST_RUN, ST_PAUSE};
    logic [1:0] lap_to[4]  = '{ST_IDLE, ST_LAP, ST_IDLE, ST_LAP};
    bit         lap_clr[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    bit         lap_lat[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    function automatic logic [5:0] rec(input logic [1:0] st, input bit clr, input bit lat);
        bit running;
        bit frozen;
        running = (st == ST_RUN) || (st == ST_LAP);
        frozen  = (st == ST_LAP);
        return {st, running, frozen, clr, lat};
    endfunction

    task automatic model_ss();
        mode = ss_to[mode];
        exp_q.push_back(rec(mode, 1'b0, 1'b0));
    endtask

    task automatic model_lap();
        if (mode != ST_IDLE) begin
            bit c;
            bit l;
            c    = lap_clr[mode];
            l    = lap_lat[mode];
            mode = lap_to[mode];
            exp_q.push_back(rec(mode, c, l));
        end
    endtask

    task automatic model_hold();
        mode = ST_IDLE;
        exp_q.push_back(rec(ST_IDLE, 1'b1, 1'b0));
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [3:0] last_lvl = 4'b0;

    always @(negedge clk) begin
        logic [5:0] cur;
        logic [5:0] exp;
        if (!rst_n) begin
            last_lvl = 4'b0;
        end else begin
            cur = {sw_if.state_o, sw_if.count_en, sw_if.disp_freeze,
                   sw_if.count_clr, sw_if.lap_latch};
            if (cur[1:0] != 2'b00 || cur[5:2] != last_lvl) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL out_seq: unexpected output %b at %0t", cur, $time);
                end else begin
                    exp = exp_q.pop_front();
                    if (cur !== exp) begin
                        n_bad++;
                        $display("FAIL out_seq: got %b expected %b at %0t", cur, exp, $time);
                    end
                end
                last_lvl = cur[5:2];
            end
        end
    end

    // Long lap holds (>=16 clk) span at least HOLD_TICKS samples; short ones at most 2.
    task automatic press(input bit do_ss, input bit do_lap, input int low_len, input bit bounce);
        if (do_ss) begin
            model_ss();
        end else if (do_lap) begin
            model_lap();
        end
`ifdef STOPWATCH_CTRL_HOLD_CLR_EN
        if (do_lap && low_len >= 16) begin
            model_hold();
        end
`endif
        @(posedge clk);
        if (bounce) begin
            for (int i = 0; i < 3; i++) begin
                btn_ss_n = i[0];
                @(posedge clk);
            end
        end
        if (do_ss) btn_ss_n = 1'b0;
        if (do_lap) btn_lap_n = 1'b0;
        repeat (low_len) @(posedge clk);
        btn_ss_n  = 1'b1;
        btn_lap_n = 1'b1;
        repeat ($urandom_range(12, 6)) @(posedge clk);
    endtask

    task automatic reset_mid_run();
        repeat (12) @(posedge clk);
        chk("pre_reset_state", 8'(sw_if.state_o), 8'(ST_RUN));
        chk("pre_reset_queue", 8'(exp_q.size()), 8'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_count_en",    8'(sw_if.count_en),    8'd0);
        chk("rst_count_clr",   8'(sw_if.count_clr),   8'd0);
        chk("rst_lap_latch",   8'(sw_if.lap_latch),   8'd0);
        chk("rst_disp_freeze", 8'(sw_if.disp_freeze), 8'd0);
        chk("rst_state_o",     8'(sw_if.state_o),     8'(ST_IDLE));
        mode = ST_IDLE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        chk("reset_state_o",  8'(sw_if.state_o),  8'(ST_IDLE));
        chk("reset_count_en", 8'(sw_if.count_en), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        press(1'b1, 1'b0, 40, 1'b0);
        reset_mid_run();
        press(1'b1, 1'b0, 10, 1'b1);
        press(1'b0, 1'b1, 8, 1'b0);
        press(1'b0, 1'b1, 8, 1'b0);
        press(1'b1, 1'b0, 8, 1'b0);
        press(1'b1, 1'b1, 8, 1'b0);
        press(1'b1, 1'b0, 8, 1'b0);
        press(1'b0, 1'b1, 8, 1'b0);
        press(1'b0, 1'b1, 8, 1'b0);
        press(1'b1, 1'b0, 8, 1'b0);
        press(1'b0, 1'b1, 40, 1'b0);

        for (int k = 0; k < 40; k++) begin
            int kind;
            kind = $urandom_range(3, 0);
            case (kind)
                0: press(1'b1, 1'b0, $urandom_range(30, 6), $urandom_range(1, 0) == 1);
                1: press(1'b0, 1'b1, $urandom_range(8, 6), 1'b0);
                2: press(1'b0, 1'b1, $urandom_range(40, 16), 1'b0);
                default: press(1'b1, 1'b1, $urandom_range(8, 6), 1'b0);
            endcase
        end

        repeat (30) @(posedge clk);
        chk("final_queue_empty", 8'(exp_q.size()), 8'd0);
        chk("final_state_o", 8'(sw_if.state_o), 8'(mode));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
